// File: rtl/seg_pkg.sv
// Shared segment encoding for the scan driver: a..g patterns, the {a..g,dp} word, and the BCD lookup.
package seg_pkg;

  localparam int SEG_W = 8;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic [6:0] agf;
    logic       dp;
  } seg_word_t;

  function automatic logic [6:0] seg_lookup(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_lookup = SEG_0;
      4'd1:    seg_lookup = SEG_1;
      4'd2:    seg_lookup = SEG_2;
      4'd3:    seg_lookup = SEG_3;
      4'd4:    seg_lookup = SEG_4;
      4'd5:    seg_lookup = SEG_5;
      4'd6:    seg_lookup = SEG_6;
      4'd7:    seg_lookup = SEG_7;
      4'd8:    seg_lookup = SEG_8;
      4'd9:    seg_lookup = SEG_9;
      default: seg_lookup = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD + dot + blank -> {a..g,dp}; blanking clears a..g only, dp passes through.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0]       i_bcd,
  input  logic             i_dot,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  seg_word_t w_word;

  always_comb begin
    w_word.agf = i_blank ? SEG_BLANK : seg_lookup(i_bcd);
    w_word.dp  = i_dot;
  end

  assign o_seg = w_word;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with dead time and optional leading-zero blanking.
// Define SEG_SCAN_DIM_EN to add the DIM[2:0] PWM brightness input.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 1000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] BCD_IN,
  input  logic [NUM_DIGITS-1:0]   DOT_IN,
  input  logic                    UPDATE,
  input  logic                    BLANK_EN,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]              DIM,
`endif
  output logic [SEG_W-1:0]        SEG_DATA,
  output logic [NUM_DIGITS-1:0]   SEG_COM
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [NUM_DIGITS-1:0][3:0] r_bcd;
  logic [NUM_DIGITS-1:0]      r_dot;
  logic [DIV_W-1:0]           r_div_cnt;
  logic [IDX_W-1:0]           r_idx;

  logic [NUM_DIGITS-1:0]      w_lead_zero;
  logic [3:0]                 w_cur_bcd;
  logic                       w_cur_dot;
  logic                       w_cur_blank;
  logic [SEG_W-1:0]           w_seg;
  logic                       w_on;
  logic                       w_div_wrap;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bcd <= '0;
      r_dot <= '0;
    end else if (UPDATE) begin
      r_bcd <= BCD_IN;
      r_dot <= DOT_IN;
    end
  end

  assign w_div_wrap = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_div_wrap)
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  // Digit i is part of the leading-zero run when every digit from the top down to i is 0.
  always_comb begin
    logic run;
    run         = 1'b1;
    w_lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run            = run && (r_bcd[i] == 4'd0);
      w_lead_zero[i] = run;
    end
  end

  assign w_cur_bcd   = r_bcd[r_idx];
  assign w_cur_dot   = r_dot[r_idx];
  assign w_cur_blank = BLANK_EN && (r_idx != '0) && w_lead_zero[r_idx];

  seg_digit_decode u_decode (
    .i_bcd   (w_cur_bcd),
    .i_dot   (w_cur_dot),
    .i_blank (w_cur_blank),
    .o_seg   (w_seg)
  );

`ifdef SEG_SCAN_DIM_EN
  logic [2:0] r_pwm;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_pwm <= '0;
    else      r_pwm <= r_pwm + 3'd1;
  end

  assign w_on = (r_div_cnt >= DIV_W'(DEAD_CYC)) &&
                ({1'b0, r_pwm} < ({1'b0, DIM} + 4'd1));
`else
  assign w_on = (r_div_cnt >= DIV_W'(DEAD_CYC));
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG_DATA <= '0;
      SEG_COM  <= '1;
    end else if (w_on) begin
      SEG_DATA <= w_seg;
      SEG_COM  <= ~(NUM_DIGITS'(1) << r_idx);
    end else begin
      SEG_DATA <= '0;
      SEG_COM  <= '1;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at NUM_DIGITS=4, CLK_DIV=8, DEAD_CYC=2.
module tb_seg_scan_driver;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BCD_IN;
  logic [3:0]  DOT_IN;
  logic        UPDATE;
  logic        BLANK_EN;
  logic [7:0]  SEG_DATA;
  logic [3:0]  SEG_COM;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]  DIM = 3'd7;
`endif

  int checks   = 0;
  int failures = 0;

  seg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .DEAD_CYC(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BCD_IN   (BCD_IN),
    .DOT_IN   (DOT_IN),
    .UPDATE   (UPDATE),
    .BLANK_EN (BLANK_EN),
`ifdef SEG_SCAN_DIM_EN
    .DIM      (DIM),
`endif
    .SEG_DATA (SEG_DATA),
    .SEG_COM  (SEG_COM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic [3:0]  dot;
    logic        blank;
    int          digit;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_com(input string name, input logic [3:0] com);
    int n;
    n = 0;
    while (SEG_COM !== com && n < 64) begin
      tick();
      n++;
    end
    if (SEG_COM !== com) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: SEG_COM=%b waiting for %b", name, SEG_COM, com);
    end
  endtask

  function automatic logic [3:0] com_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // After release, snapshot is 0 and BLANK_EN=0: digits 0 and 1 both show "0" (8'hFC).
  task automatic reset_seq(input string tag);
    int div, idx;
    logic [3:0] ec;
    logic [7:0] ed;
    for (int k = 1; k <= 12; k++) begin
      tick();
      div = (k - 1) % 8;
      idx = (k - 1) / 8;
      ec  = (div < 2) ? 4'b1111 : com_of(idx);
      ed  = (div < 2) ? 8'h00 : 8'hFC;
      chk($sformatf("%s_com_c%0d", tag, k), {28'd0, SEG_COM}, {28'd0, ec});
      chk($sformatf("%s_data_c%0d", tag, k), {24'd0, SEG_DATA}, {24'd0, ed});
    end
  endtask

  initial begin
    vecs[0]  = '{"v1234_d0", 16'h1234, 4'b0000, 1'b0, 0, 8'h66};
    vecs[1]  = '{"v1234_d1", 16'h1234, 4'b0000, 1'b0, 1, 8'hF2};
    vecs[2]  = '{"v1234_d2", 16'h1234, 4'b0000, 1'b0, 2, 8'hDA};
    vecs[3]  = '{"v1234_d3", 16'h1234, 4'b0000, 1'b0, 3, 8'h60};
    vecs[4]  = '{"lz70_d3",  16'h0070, 4'b0000, 1'b1, 3, 8'h00};
    vecs[5]  = '{"lz70_d2",  16'h0070, 4'b0000, 1'b1, 2, 8'h00};
    vecs[6]  = '{"lz70_d1",  16'h0070, 4'b0000, 1'b1, 1, 8'hE0};
    vecs[7]  = '{"lz70_d0",  16'h0070, 4'b0000, 1'b1, 0, 8'hFC};
    vecs[8]  = '{"nolz70_d3", 16'h0070, 4'b0000, 1'b0, 3, 8'hFC};
    vecs[9]  = '{"nolz70_d2", 16'h0070, 4'b0000, 1'b0, 2, 8'hFC};
    vecs[10] = '{"z_dot_d2", 16'h0000, 4'b0100, 1'b1, 2, 8'h01};
    vecs[11] = '{"z_dot_d0", 16'h0000, 4'b0100, 1'b1, 0, 8'hFC};
    vecs[12] = '{"z_dot_d1", 16'h0000, 4'b0100, 1'b1, 1, 8'h00};
    vecs[13] = '{"z_dot_d3", 16'h0000, 4'b0100, 1'b1, 3, 8'h00};
    vecs[14] = '{"blankA_d0", 16'h000A, 4'b0000, 1'b0, 0, 8'h00};

    RST = 1'b0; BCD_IN = '0; DOT_IN = '0; UPDATE = 1'b0; BLANK_EN = 1'b0;
    tick(); tick();
    chk("rst_com", {28'd0, SEG_COM}, 32'hF);
    chk("rst_data", {24'd0, SEG_DATA}, 32'h0);
    RST = 1'b1;
    reset_seq("start");

    foreach (vecs[i]) begin
      BCD_IN = vecs[i].bcd; DOT_IN = vecs[i].dot; BLANK_EN = vecs[i].blank;
      UPDATE = 1'b1; tick(); UPDATE = 1'b0;
      tick(); tick();
      wait_com(vecs[i].name, com_of(vecs[i].digit));
      chk(vecs[i].name, {24'd0, SEG_DATA}, {24'd0, vecs[i].exp});
    end

    // BCD_IN changes without UPDATE must stay invisible.
    BCD_IN = 16'h5555;
    repeat (40) tick();
    wait_com("hold_off", 4'b1111);
    wait_com("hold_d0", com_of(0));
    chk("hold_d0", {24'd0, SEG_DATA}, 32'h00);

    // Mid-slot update: old value on the next sample, new value two edges after the strobe.
    UPDATE = 1'b1; tick(); UPDATE = 1'b0;
    chk("upd_stale", {24'd0, SEG_DATA}, 32'h00);
    tick();
    chk("upd_new", {24'd0, SEG_DATA}, 32'hB6);
    chk("upd_com", {28'd0, SEG_COM}, {28'd0, com_of(0)});

    // Reset mid-slot of digit 2.
    BLANK_EN = 1'b0;
    wait_com("mid_off", 4'b1111);
    wait_com("mid_d2", com_of(2));
    tick();
    chk("mid_pre_com", {28'd0, SEG_COM}, {28'd0, com_of(2)});
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_com", {28'd0, SEG_COM}, 32'hF);
    chk("mid_rst_data", {24'd0, SEG_DATA}, 32'h0);
    tick(); tick();
    RST = 1'b1;
    reset_seq("rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
